pic_inta_sequencer: RTL and testbench



---
 rtl/pic_inta_pkg.sv | 22 ++
 rtl/pic_inta_sequencer_sync2.sv | 21 ++
 rtl/pic_inta_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_inta_pkg.sv
// Shared types and constants for the CPU-side INTA sequencer.
package pic_inta_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE1 = 3'd1,
    GAP1   = 3'd2,
    PULSE2 = 3'd3,
    GAP2   = 3'd4,
    PULSE3 = 3'd5,
    HOLD   = 3'd6
  } inta_state_e;

  localparam int unsigned PIC_PULSE_CYCLES_DEF = 4;
  localparam int unsigned PIC_GAP_CYCLES_DEF   = 2;
  localparam logic [7:0]  MCS80_CALL_OP        = 8'hCD;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_sync2.sv
// Two-flop synchronizer, async active-high reset to 0.
module pic_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-style two-pulse interrupt acknowledge sequencer driving the 8259 INTA pin.
// Optional MCS-80 three-pulse CALL sequence when PIC_INTA_MCS80_EN is defined.
module pic_inta_sequencer
  import pic_inta_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = PIC_PULSE_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = PIC_GAP_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        int_req,
  input  logic        cpu_int_enable,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        inta_busy,
  output logic        vector_valid,
  output logic [7:0]  vector,
  input  logic        vector_ack
`ifdef PIC_INTA_MCS80_EN
  ,
  input  logic        mcs80_mode,
  output logic [15:0] call_addr
`endif
);

  localparam int unsigned CNT_W = $clog2(max_u(PULSE_CYCLES, GAP_CYCLES) + 1);

  logic             int_req_sync;
  inta_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inta_n_d;
  logic             busy_d;
  logic             valid_d;
  logic [7:0]       vector_d;
`ifdef PIC_INTA_MCS80_EN
  logic             mode_q, mode_d;
  logic [15:0]      call_addr_d;
`endif

  pic_sync2 u_sync_int_req (
    .clock (clock),
    .reset (reset),
    .d     (int_req),
    .q     (int_req_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                 <= IDLE;
      cnt_q                   <= '0;
      interrupt_acknowledge_n <= 1'b1;
      inta_busy               <= 1'b0;
      vector_valid            <= 1'b0;
      vector                  <= 8'h00;
`ifdef PIC_INTA_MCS80_EN
      mode_q                  <= 1'b0;
      call_addr               <= 16'h0000;
`endif
    end else begin
      state_q                 <= state_d;
      cnt_q                   <= cnt_d;
      interrupt_acknowledge_n <= inta_n_d;
      inta_busy               <= busy_d;
      vector_valid            <= valid_d;
      vector                  <= vector_d;
`ifdef PIC_INTA_MCS80_EN
      mode_q                  <= mode_d;
      call_addr               <= call_addr_d;
`endif
    end
  end

  // Next state; outputs are derived from the next state so they align with it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = vector_valid;
    vector_d = vector;
`ifdef PIC_INTA_MCS80_EN
    mode_d      = mode_q;
    call_addr_d = call_addr;
`endif

    case (state_q)
      IDLE: begin
        if (int_req_sync && cpu_int_enable) begin
          state_d = PULSE1;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
`ifdef PIC_INTA_MCS80_EN
          mode_d  = mcs80_mode;
`endif
        end
      end
      PULSE1: begin
        if (cnt_q == '0) begin
          state_d = GAP1;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
`ifdef PIC_INTA_MCS80_EN
          if (mode_q) vector_d = data_bus_in;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP1: begin
        if (cnt_q == '0) begin
          state_d = PULSE2;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE2: begin
        if (cnt_q == '0) begin
`ifdef PIC_INTA_MCS80_EN
          if (mode_q) begin
            call_addr_d[7:0] = data_bus_in;
            state_d          = GAP2;
            cnt_d            = CNT_W'(GAP_CYCLES - 1);
          end else begin
            vector_d = data_bus_in;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
`else
          vector_d = data_bus_in;
          valid_d  = 1'b1;
          state_d  = HOLD;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef PIC_INTA_MCS80_EN
      GAP2: begin
        if (cnt_q == '0) begin
          state_d = PULSE3;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE3: begin
        if (cnt_q == '0) begin
          call_addr_d[15:8] = data_bus_in;
          valid_d           = 1'b1;
          state_d           = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      HOLD: begin
        if (vector_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    inta_n_d = !((state_d == PULSE1) || (state_d == PULSE2) || (state_d == PULSE3));
    busy_d   = (state_d != IDLE);
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: vector table plus hand-written corner sequences.
module tb_pic_inta_sequencer;
  import pic_inta_pkg::*;

  localparam int unsigned PULSE = 4;
  localparam int unsigned GAP   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        int_req;
  logic        cpu_int_enable;
  logic [7:0]  data_bus_in;
  logic        interrupt_acknowledge_n;
  logic        inta_busy;
  logic        vector_valid;
  logic [7:0]  vector;
  logic        vector_ack;
`ifdef PIC_INTA_MCS80_EN
  logic        mcs80_mode;
  logic [15:0] call_addr;
`endif

  pic_inta_sequencer #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .int_req                 (int_req),
    .cpu_int_enable          (cpu_int_enable),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .inta_busy               (inta_busy),
    .vector_valid            (vector_valid),
    .vector                  (vector),
    .vector_ack              (vector_ack)
`ifdef PIC_INTA_MCS80_EN
    ,
    .mcs80_mode              (mcs80_mode),
    .call_addr               (call_addr)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         drop;
    int         hold;
    logic [7:0] exp_vec;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count consecutive negedge samples of inta_n at lvl, starting with the current one.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (interrupt_acknowledge_n === lvl && n < 64) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (interrupt_acknowledge_n !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Entered at the first negedge sample of PULSE1; leaves after the ack edge.
  task automatic run_body(input logic [7:0] d, input logic [7:0] exp_v, input bit drop,
                          input int hold, input bit keep);
    int n;
    logic [7:0] got;
    bit ok;
    chk("busy_pulse1", inta_busy, 1);
    data_bus_in = ~d;
    run_len(1'b0, n);
    chk("pulse1_width", n, PULSE);
    if (drop) int_req = 1'b0;
    run_len(1'b1, n);
    chk("gap1_width", n, GAP);
    if (!keep) int_req = 1'b0;
    data_bus_in = d;
    exp_q.push_back(exp_v);
    run_len(1'b0, n);
    chk("pulse2_width", n, PULSE);
    data_bus_in = 8'($urandom);
    chk("valid_rise", vector_valid, 1);
    chk("inta_n_hold", interrupt_acknowledge_n, 1);
    got = exp_q.pop_front();
    chk("vector", vector, got);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      data_bus_in = 8'($urandom);
      if (interrupt_acknowledge_n !== 1'b1 || vector !== got || vector_valid !== 1'b1 ||
          inta_busy !== 1'b1) ok = 1'b0;
    end
    if (hold > 0) chk("hold_stable", ok, 1);
    vector_ack = 1'b1;
    @(negedge clock);
    vector_ack = 1'b0;
    chk("ack_valid_low", vector_valid, 0);
    chk("ack_busy_low", inta_busy, 0);
  endtask

  initial begin
    vec_t tbl[5];
    int   n;
    bit   ok;

    tbl[0] = '{data: 8'h48, drop: 1'b0, hold: 0, exp_vec: 8'h48};
    tbl[1] = '{data: 8'h4F, drop: 1'b1, hold: 3, exp_vec: 8'h4F};
    tbl[2] = '{data: 8'h00, drop: 1'b0, hold: 1, exp_vec: 8'h00};
    tbl[3] = '{data: 8'hFF, drop: 1'b1, hold: 5, exp_vec: 8'hFF};
    tbl[4] = '{data: 8'hA5, drop: 1'b0, hold: 2, exp_vec: 8'hA5};

    // Reset with random inputs, checked before the first clock edge.
    reset          = 1'b1;
    int_req        = 1'($urandom);
    cpu_int_enable = 1'($urandom);
    data_bus_in    = 8'($urandom);
    vector_ack     = 1'($urandom);
`ifdef PIC_INTA_MCS80_EN
    mcs80_mode     = 1'b0;
`endif
    #3;
    chk("rst_inta_n", interrupt_acknowledge_n, 1);
    chk("rst_busy", inta_busy, 0);
    chk("rst_valid", vector_valid, 0);
    chk("rst_vector", vector, 8'h00);
    repeat (3) begin
      @(negedge clock);
      int_req     = 1'($urandom);
      data_bus_in = 8'($urandom);
    end
    int_req        = 1'b0;
    cpu_int_enable = 1'b1;
    vector_ack     = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (interrupt_acknowledge_n !== 1'b1 || inta_busy !== 1'b0 || vector_valid !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_reset", ok, 1);

    // Table-driven sequences.
    foreach (tbl[k]) begin
      int_req = 1'b1;
      wait_fall(n);
      chk("start_latency", n, 3);
      run_body(tbl[k].data, tbl[k].exp_vec, tbl[k].drop, tbl[k].hold, 1'b0);
      ok = 1'b1;
      vector_ack = 1'b1;
      repeat (4) begin
        @(negedge clock);
        if (interrupt_acknowledge_n !== 1'b1 || vector_valid !== 1'b0) ok = 1'b0;
      end
      vector_ack = 1'b0;
      chk("idle_between", ok, 1);
    end

    // Disabled: request pending, no pulse until enable rises.
    cpu_int_enable = 1'b0;
    int_req = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (interrupt_acknowledge_n !== 1'b1 || inta_busy !== 1'b0) ok = 1'b0;
    end
    chk("disabled_quiet", ok, 1);
    cpu_int_enable = 1'b1;
    @(negedge clock);
    chk("enable_start", interrupt_acknowledge_n, 0);
    run_body(8'h3C, 8'h3C, 1'b0, 0, 1'b1);

    // Backpressure from the restarted sequence: request held across HOLD.
    @(negedge clock);
    chk("restart_after_ack_a", interrupt_acknowledge_n, 0);
    run_body(8'h5A, 8'h5A, 1'b0, 10, 1'b1);
    @(negedge clock);
    chk("restart_after_ack_b", interrupt_acknowledge_n, 0);
    run_body(8'h21, 8'h21, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clock);

    // Async reset in the middle of PULSE2.
    int_req = 1'b1;
    wait_fall(n);
    run_len(1'b0, n);
    run_len(1'b1, n);
    data_bus_in = 8'h77;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midp2_rst_inta_n", interrupt_acknowledge_n, 1);
    chk("midp2_rst_valid", vector_valid, 0);
    chk("midp2_rst_busy", inta_busy, 0);
    int_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Async reset while a vector is held.
    int_req = 1'b1;
    wait_fall(n);
    run_len(1'b0, n);
    int_req = 1'b0;
    run_len(1'b1, n);
    data_bus_in = 8'h99;
    run_len(1'b0, n);
    chk("hold_valid_pre_rst", vector_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("hold_rst_valid", vector_valid, 0);
    chk("hold_rst_vector", vector, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

`ifdef PIC_INTA_MCS80_EN
    // MCS-80 three-pulse CALL sequence.
    mcs80_mode = 1'b1;
    int_req = 1'b1;
    wait_fall(n);
    chk("mcs_latency", n, 3);
    data_bus_in = MCS80_CALL_OP;
    run_len(1'b0, n);
    chk("mcs_p1_width", n, PULSE);
    run_len(1'b1, n);
    chk("mcs_g1_width", n, GAP);
    data_bus_in = 8'h20;
    int_req = 1'b0;
    run_len(1'b0, n);
    chk("mcs_p2_width", n, PULSE);
    chk("mcs_no_early_valid", vector_valid, 0);
    run_len(1'b1, n);
    chk("mcs_g2_width", n, GAP);
    data_bus_in = 8'h00;
    exp_q.push_back(8'hCD);
    run_len(1'b0, n);
    chk("mcs_p3_width", n, PULSE);
    chk("mcs_valid", vector_valid, 1);
    chk("mcs_vector", vector, exp_q.pop_front());
    chk("mcs_call_addr", call_addr, 16'h0020);
    vector_ack = 1'b1;
    @(negedge clock);
    vector_ack = 1'b0;
    chk("mcs_ack", vector_valid, 0);
    mcs80_mode = 1'b0;
    repeat (3) @(negedge clock);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
